// File: rtl/uart_cmd_collector.sv
// Collects three UART bytes into one 24-bit command, first byte in the MSBs.
// Handles the UART receiver handshake, reports overwrites and discards partial commands on an inter-byte timeout.
module uart_cmd_collector #(
   parameter int unsigned TIMEOUT_CYC = 52080
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rx_rdy,
   output logic [23:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   output logic        ovr,
   output logic        frm_err,
   output logic        busy
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      WAIT_B0 = 2'd0,
      WAIT_B1 = 2'd1,
      WAIT_B2 = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             rx_rdy_q;
   logic [7:0]       byte0_q, byte0_d;
   logic [7:0]       byte1_q, byte1_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [23:0]      cmd_d;
   logic             cmd_rdy_d, ovr_d, frm_err_d;
   logic             capture_c, timeout_c;

   // Rising edge of the receiver flag; a capture outranks a coincident timeout.
   assign capture_c = rx_rdy & ~rx_rdy_q;
   assign timeout_c = (state_q != WAIT_B0) && (cnt_q == CNT_LAST) && !capture_c;
   assign busy      = (state_q != WAIT_B0);

   // State register plus all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WAIT_B0;
         rx_rdy_q   <= 1'b0;
         byte0_q    <= '0;
         byte1_q    <= '0;
         cnt_q      <= '0;
         cmd        <= '0;
         cmd_rdy    <= 1'b0;
         ovr        <= 1'b0;
         frm_err    <= 1'b0;
         clr_rx_rdy <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_rdy_q   <= rx_rdy;
         byte0_q    <= byte0_d;
         byte1_q    <= byte1_d;
         cnt_q      <= cnt_d;
         cmd        <= cmd_d;
         cmd_rdy    <= cmd_rdy_d;
         ovr        <= ovr_d;
         frm_err    <= frm_err_d;
         clr_rx_rdy <= capture_c;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_d   = state_q;
      byte0_d   = byte0_q;
      byte1_d   = byte1_q;
      cnt_d     = '0;
      cmd_d     = cmd;
      cmd_rdy_d = cmd_rdy;
      ovr_d     = ovr;
      frm_err_d = 1'b0;

      if (clr_cmd_rdy && cmd_rdy) begin
         cmd_rdy_d = 1'b0;
         ovr_d     = 1'b0;
      end

      unique case (state_q)
         WAIT_B0: begin
            if (capture_c) begin
               byte0_d = rx_data;
               state_d = WAIT_B1;
            end
         end
         WAIT_B1: begin
            if (capture_c) begin
               byte1_d = rx_data;
               state_d = WAIT_B2;
            end else if (timeout_c) begin
               byte0_d   = '0;
               state_d   = WAIT_B0;
               frm_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_B2: begin
            if (capture_c) begin
               // Completion wins over a same-cycle consumer acknowledge
               cmd_d     = {byte0_q, byte1_q, rx_data};
               cmd_rdy_d = 1'b1;
               if (cmd_rdy && !clr_cmd_rdy) ovr_d = 1'b1;
               byte0_d   = '0;
               byte1_d   = '0;
               state_d   = WAIT_B0;
            end else if (timeout_c) begin
               byte0_d   = '0;
               byte1_d   = '0;
               state_d   = WAIT_B0;
               frm_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = WAIT_B0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_cmd_collector.sv
// Bench for uart_cmd_collector: directed scenarios plus random traffic,
// checked every cycle against a byte-queue reference model.
module tb_uart_cmd_collector;

   localparam int unsigned T = 200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_rdy;
   logic [7:0]  rx_data;
   logic        clr_rx_rdy;
   logic [23:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        ovr;
   logic        frm_err;
   logic        busy;

   uart_cmd_collector #(.TIMEOUT_CYC(T)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_rdy      (rx_rdy),
      .rx_data     (rx_data),
      .clr_rx_rdy  (clr_rx_rdy),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .ovr         (ovr),
      .frm_err     (frm_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int n_clr    = 0;
   int n_frm    = 0;

   // Reference model: pending bytes, idle cycles since the last capture, output image
   logic [7:0]  m_q[$];
   int          m_idle;
   logic        m_prev;
   logic [23:0] m_cmd;
   logic        m_rdy, m_ovr, m_frm, m_clr;

   task automatic model_reset();
      m_q.delete();
      m_idle = 0;
      m_prev = 1'b0;
      m_cmd  = 24'h0;
      m_rdy  = 1'b0;
      m_ovr  = 1'b0;
      m_frm  = 1'b0;
      m_clr  = 1'b0;
   endtask

   task automatic model_step();
      logic cap;
      logic done;
      if (!rst_n) begin
         model_reset();
         return;
      end
      cap    = rx_rdy && !m_prev;
      m_prev = rx_rdy;
      m_clr  = cap;
      m_frm  = 1'b0;
      done   = 1'b0;
      if (cap) begin
         m_q.push_back(rx_data);
         m_idle = 0;
         if (m_q.size() == 3) done = 1'b1;
      end else if (m_q.size() != 0) begin
         m_idle++;
         if (m_idle == int'(T)) begin
            m_q.delete();
            m_idle = 0;
            m_frm  = 1'b1;
         end
      end
      if (done) begin
         if (clr_cmd_rdy) m_ovr = 1'b0;
         else if (m_rdy) m_ovr = 1'b1;
         m_rdy = 1'b1;
         m_cmd = {m_q[0], m_q[1], m_q[2]};
         m_q.delete();
      end else if (clr_cmd_rdy && m_rdy) begin
         m_rdy = 1'b0;
         m_ovr = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("cmd",        cmd,                m_cmd);
      chk("cmd_rdy",    24'(cmd_rdy),       24'(m_rdy));
      chk("ovr",        24'(ovr),           24'(m_ovr));
      chk("frm_err",    24'(frm_err),       24'(m_frm));
      chk("clr_rx_rdy", 24'(clr_rx_rdy),    24'(m_clr));
      chk("busy",       24'(busy),          24'(m_q.size() != 0));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      if (clr_rx_rdy === 1'b1) n_clr++;
      if (frm_err === 1'b1) n_frm++;
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold, input int gap, input logic clr_first);
      rx_data     = b;
      rx_rdy      = 1'b1;
      clr_cmd_rdy = clr_first;
      tick();
      clr_cmd_rdy = 1'b0;
      repeat (hold - 1) tick();
      rx_rdy = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_cmd(input logic [23:0] c);
      send_byte(c[23:16], 3, 4, 1'b0);
      send_byte(c[15:8],  3, 4, 1'b0);
      send_byte(c[7:0],   3, 4, 1'b0);
   endtask

   initial begin
      int frm0;
      rst_n       = 1'b0;
      rx_rdy      = 1'b0;
      rx_data     = 8'h00;
      clr_cmd_rdy = 1'b0;
      model_reset();
      #2;
      check_all();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // Basic three-byte command, level held high must capture once
      n_clr = 0;
      send_byte(8'hA5, 5, 100, 1'b0);
      send_byte(8'h3C, 5, 100, 1'b0);
      rx_data = 8'h0F;
      rx_rdy  = 1'b1;
      tick();
      chk("a53c0f_rdy_latency", 24'(cmd_rdy), 24'h1);
      chk("a53c0f_cmd", cmd, 24'hA53C0F);
      repeat (4) tick();
      rx_rdy = 1'b0;
      repeat (100) tick();
      chk("a53c0f_clr_pulses", 24'(n_clr), 24'd3);
      chk("a53c0f_busy", 24'(busy), 24'h0);

      // Overwrite of an unconsumed command, then acknowledge
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      send_cmd(24'h010203);
      send_cmd(24'h040506);
      chk("ovr_cmd", cmd, 24'h040506);
      chk("ovr_flag", 24'(ovr), 24'h1);
      clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      chk("ack_rdy", 24'(cmd_rdy), 24'h0);
      chk("ack_ovr", 24'(ovr), 24'h0);
      tick();

      // Timeout discards a partial command
      frm0 = n_frm;
      send_byte(8'h11, 5, int'(T) + 10, 1'b0);
      chk("timeout_frm_count", 24'(n_frm - frm0), 24'd1);
      chk("timeout_busy", 24'(busy), 24'h0);
      send_cmd(24'h223344);
      chk("after_timeout_cmd", cmd, 24'h223344);

      // Completion coincident with acknowledge while an overwrite is pending
      send_cmd(24'hAABBCC);
      chk("pre_coinc_ovr", 24'(ovr), 24'h1);
      send_byte(8'hDE, 3, 4, 1'b0);
      send_byte(8'hAD, 3, 4, 1'b0);
      send_byte(8'h01, 3, 4, 1'b1);
      chk("coinc_rdy", 24'(cmd_rdy), 24'h1);
      chk("coinc_cmd", cmd, 24'hDEAD01);
      chk("coinc_ovr", 24'(ovr), 24'h0);

      // Reset in the middle of a command
      send_byte(8'h55, 2, 3, 1'b0);
      send_byte(8'h66, 2, 3, 1'b0);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_cmd", cmd, 24'h0);
      chk("rst_flags", {18'h0, cmd_rdy, ovr, frm_err, clr_rx_rdy, busy, 1'b0}, 24'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      send_cmd(24'h778899);
      chk("post_reset_cmd", cmd, 24'h778899);

      // Second byte lands exactly on the last counter value
      frm0 = n_frm;
      send_byte(8'h5A, 5, int'(T) - 5, 1'b0);
      send_byte(8'h6B, 5, 10, 1'b0);
      chk("edge_no_frm", 24'(n_frm - frm0), 24'd0);
      chk("edge_busy", 24'(busy), 24'h1);
      send_byte(8'h7C, 2, 3, 1'b0);
      chk("edge_cmd", cmd, 24'h5A6B7C);

      // One cycle later the timeout fires first, and the late byte starts a new command
      frm0 = n_frm;
      send_byte(8'h12, 5, int'(T) - 4, 1'b0);
      send_byte(8'h34, 2, 3, 1'b0);
      chk("late_frm", 24'(n_frm - frm0), 24'd1);
      send_byte(8'h56, 2, 3, 1'b0);
      send_byte(8'h78, 2, 3, 1'b0);
      chk("late_cmd", cmd, 24'h345678);

      // Random traffic with idle stretches around the timeout boundary
      for (int blk = 0; blk < 8; blk++) begin
         for (int c = 0; c < 400; c++) begin
            if (!rx_rdy && ($urandom_range(0, 5) == 0)) begin
               rx_rdy  = 1'b1;
               rx_data = 8'($urandom);
            end else if (rx_rdy && ($urandom_range(0, 2) == 0)) begin
               rx_rdy = 1'b0;
            end
            clr_cmd_rdy = ($urandom_range(0, 9) == 0);
            tick();
         end
         rx_rdy      = 1'b0;
         clr_cmd_rdy = 1'b0;
         repeat ($urandom_range(int'(T) - 3, int'(T) + 3)) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_cmd_collector.md
UART_CMD_COLLECTOR -- requirements
Module: uart_cmd_collector

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 52080, the maximum gap in clk cycles between bytes of one command (2 byte times at 19200 baud, 50 MHz).
REQ-002 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset.
REQ-004 Port rx_rdy, input, 1: byte-ready flag from the UART receiver.
REQ-005 Port rx_data, input, 8: received byte; valid while rx_rdy=1.
REQ-006 Port clr_rx_rdy, output, 1: one-cycle pulse acknowledging the byte to the UART receiver.
REQ-007 Port cmd, output, 24: assembled command {byte0, byte1, byte2}, with the first byte received in the MSBs.
REQ-008 Port cmd_rdy, output, 1: the value on cmd is valid and unconsumed.
REQ-009 Port clr_cmd_rdy, input, 1: consumer acknowledge; clears cmd_rdy.
REQ-010 Port ovr, output, 1: sticky flag; a new command overwrote an unconsumed one.
REQ-011 Port frm_err, output, 1: one-cycle pulse; a partial command was discarded on timeout.
REQ-012 Port busy, output, 1: high while a partial command is held (state not WAIT_B0).

Function
REQ-013 A byte SHALL be captured only on a rising edge of rx_rdy (rx_rdy=1 and its registered previous value=0); a level held high SHALL NOT be captured twice.
REQ-014 clr_rx_rdy SHALL be registered and high for exactly the one cycle following each capture edge.
REQ-015 The FSM SHALL have states WAIT_B0, WAIT_B1 and WAIT_B2.
REQ-016 FSM transitions on capture: WAIT_B0->WAIT_B1 storing byte0; WAIT_B1->WAIT_B2 storing byte1; WAIT_B2->WAIT_B0 completing the command.
REQ-017 On completion, cmd SHALL load {byte0, byte1, rx_data} and cmd_rdy SHALL be set on the same edge, i.e. 1 cycle after rx_rdy rises.
REQ-018 cmd SHALL hold its value between completions, independent of cmd_rdy.
REQ-019 clr_cmd_rdy=1 SHALL clear cmd_rdy and ovr on the next edge; clr_cmd_rdy while cmd_rdy=0 SHALL have no effect.
REQ-020 Byte collection SHALL continue while cmd_rdy=1.
REQ-021 A completion while cmd_rdy=1 and clr_cmd_rdy=0 SHALL overwrite cmd, keep cmd_rdy=1 and set ovr.
REQ-022 When a completion and clr_cmd_rdy=1 occur in the same cycle, the completion SHALL win: cmd_rdy=1, cmd updated, ovr cleared and not set.
REQ-023 The gap counter, sized $clog2(TIMEOUT_CYC+1) bits, SHALL clear on every capture and in WAIT_B0, and SHALL count up each cycle in WAIT_B1 and WAIT_B2.
REQ-024 When the counter equals TIMEOUT_CYC-1 with no capture that cycle, the FSM SHALL return to WAIT_B0, discard the partial bytes, pulse frm_err for one cycle and clear the counter; cmd, cmd_rdy and ovr SHALL be unaffected.
REQ-025 A capture in the same cycle the counter reaches TIMEOUT_CYC-1 SHALL take priority over the timeout.
REQ-026 busy SHALL be a combinational decode of state != WAIT_B0.

Reset
REQ-027 rst_n=0 SHALL immediately force state=WAIT_B0, cmd=24'h000000, cmd_rdy=0, ovr=0, frm_err=0, clr_rx_rdy=0, counter=0, stored bytes=0 and rx_rdy history=0.
REQ-028 A reset asserted mid-command SHALL discard all partial bytes; the first rx_rdy rise after release SHALL be treated as byte0.

Verification
REQ-029 Bytes 8'hA5, 8'h3C, 8'h0F, each with rx_rdy held high 5 cycles and 100 cycles between bytes -> exactly 3 clr_rx_rdy pulses, cmd=24'hA53C0F, cmd_rdy=1 one cycle after the third rx_rdy rise, busy=0 afterwards.
REQ-030 Command 24'h010203 left unconsumed, then command 24'h040506 -> cmd=24'h040506, cmd_rdy=1, ovr=1; a following clr_cmd_rdy pulse -> cmd_rdy=0, ovr=0.
REQ-031 Byte 8'h11 followed by no activity for TIMEOUT_CYC cycles -> frm_err pulses once, busy=0; then 8'h22, 8'h33, 8'h44 -> cmd=24'h223344.
REQ-032 clr_cmd_rdy asserted in the same cycle as completion of 24'hDEAD01 while cmd_rdy=1 -> cmd_rdy=1, cmd=24'hDEAD01, ovr=0.
REQ-033 rst_n pulsed low after 2 bytes, then bytes 8'h77, 8'h88, 8'h99 -> cmd=24'h778899 and all outputs at reset values during reset.
REQ-034 Second byte captured exactly at counter=TIMEOUT_CYC-1 -> no frm_err, state=WAIT_B2.
